// File: rtl/mic_frame_controller_pkg.sv
// Shared types for the microphone capture path: sample width, sample type,
// controller state encoding and a saturating counter helper.
package mic_pkg;

   localparam int SAMPLE_W = 12;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } mic_state_t;

   // Increment an 8-bit count, holding at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : (v + 8'd1);
   endfunction

endpackage

// File: rtl/mic_frame_controller_if.sv
// Frame handoff to the spectrum engine: an N-sample frame plus its sequence
// number, transferred on frame_valid & frame_ready.
interface mic_frame_if import mic_pkg::*; #(parameter int N = 16) ();

   sample_t     frame_data [0:N-1];
   logic        frame_valid;
   logic        frame_ready;
   logic [7:0]  frame_seq;

   modport master (output frame_data, output frame_valid, output frame_seq, input frame_ready);
   modport slave  (input frame_data, input frame_valid, input frame_seq, output frame_ready);

endinterface

// File: rtl/mic_frame_controller_tick_gen.sv
// Sample strobe generator: counts 0..DIV-1 while enabled and pulses tick in
// the cycle the count sits at DIV-1, giving one tick every DIV clocks.
module sample_tick_gen #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   // Next count and registered tick flag (high only when the count advanced onto LAST).
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         tick_d = (cnt_d == LAST);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter and tick registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/mic_frame_controller.sv
// Microphone frame controller: derives the sample strobe, keeps an N-deep
// sliding window of ADC samples and every HOP samples offers a frame snapshot
// downstream, counting frames lost while the consumer stalls.
module mic_frame_controller import mic_pkg::*; #(
   parameter int CLK_HZ    = 10000000,
   parameter int SAMPLE_HZ = 5000,
   parameter int N         = 16,
   parameter int HOP       = 8
) (
   input  logic        clk_10MHz,
   input  logic        rst,
   input  logic        enable,
   input  sample_t     adc_sample,
   output logic        sample_tick,
   mic_frame_if.master frame_if,
   output logic [7:0]  overrun_count,
   output logic        filling
);

   localparam int DIV = CLK_HZ / SAMPLE_HZ;
   localparam int FW  = $clog2(N + 1);
   localparam int HW  = $clog2(HOP + 1);

   mic_state_t    state_q, state_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [HW-1:0] hop_q, hop_d;
   logic          due_q, due_d;
   logic          filling_q, filling_d;
   sample_t       window_q [0:N-1];
   sample_t       window_d [0:N-1];
   sample_t       frame_data_q [0:N-1];
   sample_t       frame_data_d [0:N-1];
   logic          valid_q, valid_d;
   logic [7:0]    seq_q, seq_d;
   logic [7:0]    ovr_q, ovr_d;
   logic          tick;
   logic          tick_en;
   logic          tick_clr;
   logic          accept;

   // The divider only runs outside IDLE and is zeroed as soon as enable drops.
   assign tick_en  = (state_q != IDLE);
   assign tick_clr = (state_q == IDLE) || !enable;

   sample_tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk  (clk_10MHz),
      .rst  (rst),
      .en   (tick_en),
      .clr  (tick_clr),
      .tick (tick)
   );

   // Window shift, state sequencing and fill/hop counting; a due flag is
   // registered so the frame decision sees the already-shifted window.
   always_comb begin
      state_d  = state_q;
      fill_d   = fill_q;
      hop_d    = hop_q;
      due_d    = 1'b0;
      window_d = window_q;
      if (tick) begin
         for (int i = 0; i < N - 1; i++) begin
            window_d[i] = window_q[i + 1];
         end
         window_d[N - 1] = adc_sample;
      end else begin
         window_d = window_q;
      end
      case (state_q)
         IDLE: begin
            fill_d = '0;
            hop_d  = '0;
            if (enable) begin
               state_d = FILL;
            end else begin
               state_d = IDLE;
            end
         end
         FILL: begin
            if (!enable) begin
               state_d = IDLE;
               fill_d  = '0;
               hop_d   = '0;
            end else if (tick) begin
               if (fill_q == FW'(N - 1)) begin
                  state_d = RUN;
                  fill_d  = '0;
                  hop_d   = '0;
                  due_d   = 1'b1;
               end else begin
                  fill_d = fill_q + FW'(1);
               end
            end else begin
               state_d = FILL;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
               fill_d  = '0;
               hop_d   = '0;
            end else if (tick) begin
               if (hop_q == HW'(HOP - 1)) begin
                  hop_d = '0;
                  due_d = 1'b1;
               end else begin
                  hop_d = hop_q + HW'(1);
               end
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            fill_d  = '0;
            hop_d   = '0;
         end
      endcase
      filling_d = (state_d == FILL);
   end

   assign accept = valid_q && frame_ready_in();

   function automatic logic frame_ready_in();
      return frame_if.frame_ready;
   endfunction

   // Output frame handshake: load a due frame when the slot is free or being
   // accepted this cycle, otherwise drop it and count the overrun.
   always_comb begin
      frame_data_d = frame_data_q;
      valid_d      = valid_q;
      seq_d        = seq_q;
      ovr_d        = ovr_q;
      if (due_q && (!valid_q || accept)) begin
         frame_data_d = window_q;
         valid_d      = 1'b1;
         seq_d        = seq_q + 8'd1;
      end else if (due_q) begin
         ovr_d = sat_inc8(ovr_q);
      end else if (accept) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // All state registers with synchronous active-high reset.
   always_ff @(posedge clk_10MHz) begin
      if (rst) begin
         state_q      <= IDLE;
         fill_q       <= '0;
         hop_q        <= '0;
         due_q        <= 1'b0;
         filling_q    <= 1'b0;
         window_q     <= '{default: '0};
         frame_data_q <= '{default: '0};
         valid_q      <= 1'b0;
         seq_q        <= 8'hFF;
         ovr_q        <= 8'd0;
      end else begin
         state_q      <= state_d;
         fill_q       <= fill_d;
         hop_q        <= hop_d;
         due_q        <= due_d;
         filling_q    <= filling_d;
         window_q     <= window_d;
         frame_data_q <= frame_data_d;
         valid_q      <= valid_d;
         seq_q        <= seq_d;
         ovr_q        <= ovr_d;
      end
   end

   assign sample_tick          = tick;
   assign frame_if.frame_data  = frame_data_q;
   assign frame_if.frame_valid = valid_q;
   assign frame_if.frame_seq   = seq_q;
   assign overrun_count        = ovr_q;
   assign filling              = filling_q;

endmodule

// File: tb/tb_mic_frame_controller.sv
// Scoreboard bench for mic_frame_controller with DIV=10, N=16, HOP=8 and
// adc_sample equal to the index of the current sample tick.
module tb_mic_frame_controller;

   localparam int N = 16;

   typedef struct {
      int base;
      int seq;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [11:0] adc_sample;
   logic        sample_tick;
   logic [7:0]  overrun_count;
   logic        filling;

   int   cyc   = 0;
   int   c0    = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   mic_frame_if #(.N(N)) fif ();

   mic_frame_controller #(
      .CLK_HZ(100), .SAMPLE_HZ(10), .N(N), .HOP(8)
   ) dut (
      .clk_10MHz     (clk),
      .rst           (rst),
      .enable        (enable),
      .adc_sample    (adc_sample),
      .sample_tick   (sample_tick),
      .frame_if      (fif),
      .overrun_count (overrun_count),
      .filling       (filling)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Go to the negedge of relative cycle c.
   task automatic at_neg(input int c);
      do @(negedge clk); while ((cyc - c0) < c);
   endtask

   // Go to just after the posedge that starts relative cycle c.
   task automatic at_pos(input int c);
      do begin @(posedge clk); #1; end while ((cyc - c0) < c);
   endtask

   task automatic start(input bit rdy);
      rst = 1'b1; enable = 1'b0; fif.frame_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0; enable = 1'b1; fif.frame_ready = rdy; c0 = cyc;
   endtask

   task automatic check_reset(input string tag);
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += int'(fif.frame_data[i]);
      chk({tag, "_valid"}, fif.frame_valid, 0);
      chk({tag, "_seq"}, fif.frame_seq, 255);
      chk({tag, "_overrun"}, overrun_count, 0);
      chk({tag, "_filling"}, filling, 0);
      chk({tag, "_tick"}, sample_tick, 0);
      chk({tag, "_data"}, s, 0);
   endtask

   // ADC model: value is the number of ticks seen since the last reset.
   initial begin
      adc_sample = 12'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            adc_sample = 12'd0;
         end else if (sample_tick) begin
            @(posedge clk); #1;
            adc_sample = adc_sample + 12'd1;
         end
      end
   end

   // Monitor: every accepted frame is compared with the oldest expectation.
   initial begin
      exp_t e;
      bit   bad;
      forever begin
         @(negedge clk);
         if (!rst && fif.frame_valid && fif.frame_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_frame: got seq %0d data0 %0d, expected no frame",
                        fif.frame_seq, fif.frame_data[0]);
            end else begin
               e   = exp_q.pop_front();
               bad = (fif.frame_seq != 8'(e.seq));
               for (int i = 0; i < N; i++)
                  if (fif.frame_data[i] != 12'(e.base + i)) bad = 1'b1;
               if (bad) begin
                  n_err++;
                  $display("FAIL frame: got seq %0d data[0] %0d data[15] %0d, expected seq %0d data %0d..%0d",
                           fif.frame_seq, fif.frame_data[0], fif.frame_data[N-1], e.seq, e.base, e.base + N - 1);
               end
            end
         end
      end
   end

   initial begin
      int t1, t2, v1, v2, fa, fb, vclr, nt, nf;

      // Power-on reset values.
      rst = 1'b1; enable = 1'b0; fif.frame_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("por");

      // Ready tied high: tick timing, fill, frames every 80 cycles.
      start(1'b1);
      exp_q.push_back('{0, 0});
      exp_q.push_back('{8, 1});
      exp_q.push_back('{16, 2});
      t1 = -1; t2 = -1; v1 = -1; v2 = -1; fa = -1; fb = -1; vclr = -1;
      for (int c = 0; c <= 330; c++) begin
         at_neg(c);
         if (sample_tick && t1 < 0) t1 = c;
         else if (sample_tick && t2 < 0) t2 = c;
         if (fif.frame_valid && v1 < 0) v1 = c;
         else if (fif.frame_valid && v1 >= 0 && v2 < 0 && c > v1 + 1) v2 = c;
         if (c == 159) fa = filling;
         if (c == 161) fb = filling;
         if (c == 163) vclr = fif.frame_valid;
      end
      chk("first_tick", t1, 10);
      chk("second_tick", t2, 20);
      chk("filling_before_16", fa, 1);
      chk("filling_after_16", fb, 0);
      chk("first_valid", v1, 162);
      chk("valid_clear_after_accept", vclr, 0);
      chk("second_valid", v2, 242);
      chk("no_overrun_ready_high", overrun_count, 0);
      chk("drain_s1", exp_q.size(), 0);

      // Ready low through three frame-due points.
      start(1'b0);
      exp_q.push_back('{0, 0});
      at_neg(170);
      chk("ovr_before_drop", overrun_count, 0);
      at_neg(242);
      chk("ovr_first_drop", overrun_count, 1);
      at_neg(410);
      chk("ovr_three", overrun_count, 3);
      chk("held_valid", fif.frame_valid, 1);
      chk("held_seq", fif.frame_seq, 0);
      at_pos(411);
      fif.frame_ready = 1'b1;
      at_neg(412);
      chk("valid_clear_late_ready", fif.frame_valid, 0);
      at_pos(413);
      fif.frame_ready = 1'b0;
      chk("drain_s2", exp_q.size(), 0);

      // Ready asserted exactly in the cycle a new frame is due.
      start(1'b0);
      exp_q.push_back('{0, 0});
      exp_q.push_back('{8, 1});
      at_neg(240);
      chk("pre_due_seq", fif.frame_seq, 0);
      at_pos(241);
      fif.frame_ready = 1'b1;
      at_pos(242);
      fif.frame_ready = 1'b0;
      at_neg(242);
      chk("same_cycle_valid", fif.frame_valid, 1);
      chk("same_cycle_seq", fif.frame_seq, 1);
      chk("same_cycle_no_ovr", overrun_count, 0);
      at_pos(243);
      fif.frame_ready = 1'b1;
      at_pos(244);
      fif.frame_ready = 1'b0;
      at_neg(245);
      chk("same_cycle_final_valid", fif.frame_valid, 0);
      chk("drain_s3", exp_q.size(), 0);

      // Enable dropped after 10 ticks, then re-raised.
      start(1'b1);
      at_neg(100);
      chk("s4_filling_mid", filling, 1);
      at_pos(101);
      enable = 1'b0;
      at_neg(103);
      chk("s4_filling_idle", filling, 0);
      at_pos(106);
      enable = 1'b1;
      c0 = cyc;
      exp_q.push_back('{10, 0});
      v1 = -1; fa = -1;
      for (int c = 0; c <= 170; c++) begin
         at_neg(c);
         if (fif.frame_valid && v1 < 0) v1 = c;
         if (c == 5) fa = filling;
      end
      chk("reen_filling", fa, 1);
      chk("reen_first_valid", v1, 162);
      chk("drain_s4", exp_q.size(), 0);

      // Reset pulse while a frame is pending in RUN.
      start(1'b0);
      at_neg(170);
      chk("s5_pending", fif.frame_valid, 1);
      at_pos(171);
      rst = 1'b1; enable = 1'b0;
      at_pos(172);
      rst = 1'b0;
      at_neg(172);
      check_reset("midrun");
      nt = 0; nf = 0;
      for (int c = 173; c <= 202; c++) begin
         at_neg(c);
         if (sample_tick) nt++;
         if (filling) nf++;
      end
      chk("idle_no_tick", nt, 0);
      chk("idle_no_filling", nf, 0);

      // Overrun saturation: 300 drops with ready held low.
      start(1'b0);
      at_neg(20500);
      chk("ovr_254", overrun_count, 254);
      at_neg(24200);
      chk("ovr_saturated", overrun_count, 255);
      chk("sat_seq_held", fif.frame_seq, 0);
      chk("drain_s6", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mic_frame_controller.md
# mic_frame_controller

Sequences microphone capture for the visualizer. It generates the ADC sampling strobe from the 10 MHz clock and shifts 12-bit ADC samples into an N-deep sliding window. Every HOP new samples it snapshots the window into a stable frame and hands that frame to the downstream spectrum engine over a valid/ready handshake. It sits between the ADC wrapper and the FFT/binning stage, and counts frames that are dropped because the consumer stalled.

## Interface
- CLK_HZ, 10000000, input clock frequency
- SAMPLE_HZ, 5000, sample rate; DIV = CLK_HZ/SAMPLE_HZ (integer, ≥2)
- N, 16, window/frame length in samples
- HOP, 8, new samples between frames (1 ≤ HOP ≤ N)
- clk_10MHz  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run capture; low = idle
- adc_sample  in  12  current ADC CH0 conversion, unsigned
- sample_tick  out  1  one-cycle pulse at SAMPLE_HZ
- frame_data  out  12×N  unpacked [0:N-1]; index N-1 newest, 0 oldest
- frame_valid  out  1  frame_data holds an unconsumed frame
- frame_ready  in  1  consumer accepts frame when high with frame_valid
- frame_seq  out  8  sequence number of presented frame, wraps 255→0
- overrun_count  out  8  dropped frames, saturates at 255
- filling  out  1  high while fewer than N samples captured since enable

## Operation
- States: IDLE, FILL, RUN.
- IDLE: entered on reset or enable low. Divider counter held at 0, fill and hop counters cleared, filling=0. Window contents retained. Pending frame_valid/frame_data are unaffected and remain until accepted.
- On enable high, IDLE→FILL, filling=1. On each sample_tick, window[N-1] ← adc_sample and window[i] ← window[i+1]; fill count increments.
- FILL→RUN on the tick that captures the N-th sample; filling drops and a frame becomes due. In RUN, the hop counter counts ticks 1..HOP; reaching HOP makes a frame due and resets the counter to 0.
- Frame due with frame_valid=0, or with frame_valid=1 and frame_ready=1 in the same cycle:
  - frame_data ← window, frame_valid=1, frame_seq increments (first frame after reset is 0).
- Frame due with frame_valid=1 and frame_ready=0:
  - new frame dropped; frame_data, frame_valid and frame_seq unchanged; overrun_count += 1, saturating.
- Handshake: transfer on frame_valid & frame_ready. frame_data and frame_seq are stable while frame_valid=1 and not accepted. If no frame is loaded in the accept cycle, frame_valid clears. frame_ready while frame_valid=0 is ignored.
- enable low mid-FILL or mid-RUN returns to IDLE at the next edge. A frame due in that same cycle is still loaded or dropped per the rules above.
- Reset values: sample_tick=0, frame_data all 0, frame_valid=0, frame_seq=255 (so the first frame is 0), overrun_count=0, filling=0, window all 0, state IDLE.

## Timing
- Divider counts 0..DIV-1 while enable=1; sample_tick=1 exactly when count=DIV-1, giving period DIV cycles. The first tick occurs DIV cycles after enable rises.
- Window shift happens at the edge ending the tick cycle T.
- Frame-due is evaluated in cycle T+1 from the registered counters. frame_data/frame_valid update at the edge ending T+1 and are visible from cycle T+2, a latency of 2 cycles from tick.
- Minimum frame spacing is HOP·DIV cycles, so at most one frame is due per cycle.
- Reset dominates all other inputs in the same cycle.

## Structure
- Shared package mic_pkg: SAMPLE_W=12, typedef sample_t (logic [11:0]), state enum mic_state_t {IDLE, FILL, RUN}.
- Sub-module sample_tick_gen #(DIV): counter with enable and synchronous clear, outputs the tick. Replaces the ad hoc clock_divider-driven sampling clock, so everything runs on clk_10MHz.
- Window shift register, fill/hop counters and handshake logic live in the top module.

## Test plan
Bench parameters: CLK_HZ=100, SAMPLE_HZ=10 (DIV=10), N=16, HOP=8, adc_sample = tick index.
- Enable held after reset → sample_tick every 10 cycles, first at cycle 10 after enable. filling=1 until 16th tick. First frame_valid at tick16+2 cycles with frame_data[0..15]=0..15 and frame_seq=0.
- frame_ready tied high → frames every 80 cycles. Second frame is data 8..23, seq=1. overrun_count stays 0.
- frame_ready low through three frame-due points after first frame → frame_data stays 0..15, seq 0, overrun_count=3. Raising ready then clears frame_valid after one cycle.
- frame_ready asserted in the exact cycle a new frame is due → old frame accepted, new frame loaded the same edge, frame_valid stays 1, seq increments by 1, no overrun.
- enable dropped after 10 ticks then re-raised → filling restarts. First frame arrives after 16 further ticks and holds the 16 newest samples.
- rst pulsed while frame_valid=1 mid-RUN → next cycle: all outputs at reset values, state IDLE. overrun_count saturation check: 300 forced drops → 255.
